// File: rtl/cache_evict_buf_pkg.sv
// Shared constants, drain-state enum and state decode for the cache eviction buffer.
package cache_pkg;

    localparam int unsigned LINE_W         = 256;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BEATS_PER_LINE = 8;
    localparam int unsigned OFFSET_BITS    = 5;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_BURST = 1'b1
    } drain_state_t;

    // Fixed-width ASCII name of a drain state for debug string probes.
    function automatic logic [8*7-1:0] drain_state_str(input drain_state_t s);
        return (s == D_BURST) ? "D_BURST" : "D_IDLE ";
    endfunction

endpackage

// File: rtl/cache_evict_buf_if.sv
// Victim hand-off, allocate-path lookup and main-memory write-beat signals of the eviction buffer.
interface cache_evict_buf_if #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned LA_W = ADDR_W - cache_pkg::OFFSET_BITS;

    logic              ev_valid;
    logic              ev_ready;
    logic [LA_W-1:0]   ev_laddr;
    logic [LINE_W-1:0] ev_data;

    logic [LA_W-1:0]   lk_laddr;
    logic              lk_hit;
    logic [LINE_W-1:0] lk_data;

    logic              mm_wvalid;
    logic              mm_wready;
    logic [ADDR_W-1:0] mm_addr;
    logic [WORD_W-1:0] mm_wdata;
    logic              mm_wlast;

    modport slave (
        input  ev_valid, ev_laddr, ev_data, lk_laddr, mm_wready,
        output ev_ready, lk_hit, lk_data, mm_wvalid, mm_addr, mm_wdata, mm_wlast
    );

    modport master (
        output ev_valid, ev_laddr, ev_data, lk_laddr, mm_wready,
        input  ev_ready, lk_hit, lk_data, mm_wvalid, mm_addr, mm_wdata, mm_wlast
    );

endinterface

// File: rtl/cache_evict_buf_match.sv
// Newest-match priority selector: finds the most recently pushed valid entry holding lk_laddr.
module evict_match #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned LA_W   = 27,
    parameter int unsigned PTR_W  = 1
) (
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [LA_W-1:0]   lk_laddr,
    input  logic [DEPTH-1:0]  ent_valid,
    input  logic [LA_W-1:0]   ent_laddr [DEPTH],
    input  logic [LINE_W-1:0] ent_data  [DEPTH],
    output logic              lk_hit,
    output logic [LINE_W-1:0] lk_data
);

    logic [PTR_W-1:0] idx;

    // wr_ptr is the oldest slot; walking forward from it lets newer matches override older ones.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = wr_ptr + PTR_W'(k);
            if (ent_valid[idx] && (ent_laddr[idx] == lk_laddr)) begin
                lk_hit  = 1'b1;
                lk_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/cache_evict_buf.sv
// Write-back eviction buffer: queues dirty victim lines and drains them in order as 8-beat bursts.
module cache_evict_buf #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LINE_W = cache_pkg::LINE_W,
    parameter int unsigned WORD_W = cache_pkg::WORD_W,
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    cache_evict_buf_if.slave   bus,
    output logic               empty
);
    import cache_pkg::*;

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LA_W   = ADDR_W - OFFSET_BITS;
    localparam int unsigned BEAT_W = $clog2(BEATS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    logic [DEPTH-1:0]  ent_valid;
    logic [LA_W-1:0]   ent_laddr [DEPTH];
    logic [LINE_W-1:0] ent_data  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [BEAT_W-1:0] beat;
    drain_state_t      state;
    logic              push, pop;

    assign bus.ev_ready  = (count != CNT_W'(DEPTH));
    assign push          = bus.ev_valid && bus.ev_ready;
    assign pop           = (state == D_BURST) && bus.mm_wready && (beat == LAST_BEAT);
    assign count_nxt     = count + CNT_W'(push) - CNT_W'(pop);
    assign empty         = (count == '0) && (state == D_IDLE);

    assign bus.mm_wvalid = (state == D_BURST);
    assign bus.mm_wlast  = bus.mm_wvalid && (beat == LAST_BEAT);
    assign bus.mm_addr   = bus.mm_wvalid ? {ent_laddr[rd_ptr], beat, 2'b00} : '0;
    assign bus.mm_wdata  = bus.mm_wvalid ? ent_data[rd_ptr][WORD_W*beat +: WORD_W] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_laddr[i] <= '0;
                ent_data[i]  <= '0;
            end
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_laddr[wr_ptr] <= bus.ev_laddr;
                ent_data[wr_ptr]  <= bus.ev_data;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Continuing straight into the next burst on the last-beat edge avoids an idle cycle between lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= D_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (count != '0) begin
                        state <= D_BURST;
                        beat  <= '0;
                    end
                end
                D_BURST: begin
                    if (bus.mm_wready) begin
                        if (beat == LAST_BEAT) begin
                            beat <= '0;
                            if (count_nxt == '0) state <= D_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= D_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    evict_match #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .LA_W   (LA_W),
        .PTR_W  (PTR_W)
    ) u_match (
        .wr_ptr    (wr_ptr),
        .lk_laddr  (bus.lk_laddr),
        .ent_valid (ent_valid),
        .ent_laddr (ent_laddr),
        .ent_data  (ent_data),
        .lk_hit    (bus.lk_hit),
        .lk_data   (bus.lk_data)
    );

endmodule
